lfsr_keyspace_dispenser: RTL and testbench

//  Parametrised LFSR key-space generator for the RC4 brute-force engine.
//  One maximal-length Fibonacci LFSR serves up to NUM_CH decrypt cores.

---
 rtl/lfsr_keyspace_dispenser_if.sv | 35 +++
 rtl/lfsr_keyspace_dispenser.sv | 163 ++++++++++++++++
 tb/tb_lfsr_keyspace_dispenser.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_keyspace_dispenser_if.sv
// Key-dispenser bus between the RC4 decrypt cores (master) and the LFSR
// key-space dispenser (slave).
//   start/seed   run control: load seed and begin a run
//   stop         level, halts dispensing once a core has found the key
//   req          per-core level request for one key
//   grant/key    one-hot owner and the key it receives this cycle
//   key_valid    any grant this cycle
//   busy         dispenser is running
//   exhausted    whole key space has been issued
//   issued_count keys granted since the last start
interface lfsr_keyspace_dispenser_if #(
    parameter int unsigned WIDTH  = 22,
    parameter int unsigned NUM_CH = 4
);
    logic              start;
    logic [WIDTH-1:0]  seed;
    logic              stop;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [WIDTH-1:0]  key;
    logic              key_valid;
    logic              busy;
    logic              exhausted;
    logic [WIDTH-1:0]  issued_count;

    modport master (
        output start, seed, stop, req,
        input  grant, key, key_valid, busy, exhausted, issued_count
    );

    modport slave (
        input  start, seed, stop, req,
        output grant, key, key_valid, busy, exhausted, issued_count
    );
endinterface

// File: rtl/lfsr_keyspace_dispenser.sv
// LFSR key-space dispenser for the RC4 brute-force engine.
// A maximal-length Fibonacci LFSR walks the non-zero key space once per run
// and hands one key per cycle to a core picked by a round-robin arbiter.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    lfsr_keyspace_dispenser_if.slave (run control, requests, grants)
module lfsr_keyspace_dispenser #(
    parameter int unsigned WIDTH  = 22,
    parameter int unsigned NUM_CH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    lfsr_keyspace_dispenser_if.slave   bus
);

    localparam int unsigned IDXW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Elaboration-time legality checks
    generate
        if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 22 || WIDTH == 24)) begin : g_bad_width
            $error("lfsr_keyspace_dispenser: WIDTH must be 4, 8, 16, 22 or 24");
        end
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
            $error("lfsr_keyspace_dispenser: NUM_CH must be 1..8");
        end
    endgenerate

    // Feedback taps for a maximal-length sequence at each legal width
    function automatic logic [WIDTH-1:0] taps_for(input int unsigned w);
        case (w)
            4:       return WIDTH'(4'h9);
            8:       return WIDTH'(8'hB8);
            16:      return WIDTH'(16'hD008);
            22:      return WIDTH'(22'h200001);
            24:      return WIDTH'(24'h80000D);
            default: return '0;
        endcase
    endfunction

    localparam logic [WIDTH-1:0] TAPS = taps_for(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q,  state_d;
    logic [WIDTH-1:0]  lfsr_q,   lfsr_d;
    logic [WIDTH-1:0]  seed_q,   seed_d;
    logic [NUM_CH-1:0] grant_q,  grant_d;
    logic [WIDTH-1:0]  key_q,    key_d;
    logic              kv_q,     kv_d;
    logic [WIDTH-1:0]  issued_q, issued_d;
    logic [IDXW-1:0]   rr_q,     rr_d;

    logic [WIDTH-1:0]  lfsr_next;
    logic [WIDTH-1:0]  seed_load;
    logic [NUM_CH-1:0] eligible;
    logic              pick_valid;
    logic [IDXW-1:0]   pick_idx;

    assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    // The all-zero state is the LFSR lock-up state, so a zero seed becomes 1
    assign seed_load = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
    // A core granted this cycle cannot be granted again on the next edge
    assign eligible  = bus.req & ~grant_q;

    // Round-robin pick: first eligible index after the last winner, wrapping.
    // Scanning offsets downward lets the smallest offset win.
    always_comb begin
        int unsigned cand;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int off = int'(NUM_CH); off >= 1; off--) begin
            cand = 32'(rr_q) + 32'(off);
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = IDXW'(cand);
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        seed_d   = seed_q;
        grant_d  = '0;
        key_d    = key_q;
        kv_d     = 1'b0;
        issued_d = issued_q;
        rr_d     = rr_q;

        case (state_q)
            IDLE, HALT, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    lfsr_d   = seed_load;
                    seed_d   = seed_load;
                    issued_d = '0;
                end
            end
            RUN: begin
                // start in RUN is not a reload, but it still blocks grants and stop
                if (!bus.start) begin
                    if (bus.stop) begin
                        state_d = HALT;
                    end else if (pick_valid) begin
                        grant_d  = NUM_CH'(1) << pick_idx;
                        key_d    = lfsr_q;
                        kv_d     = 1'b1;
                        lfsr_d   = lfsr_next;
                        issued_d = issued_q + WIDTH'(1);
                        rr_d     = pick_idx;
                        // Returning to the seed means this grant carried the last key
                        if (lfsr_next == seed_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lfsr_q   <= '0;
            seed_q   <= '0;
            grant_q  <= '0;
            key_q    <= '0;
            kv_q     <= 1'b0;
            issued_q <= '0;
            rr_q     <= IDXW'(NUM_CH - 1);
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            seed_q   <= seed_d;
            grant_q  <= grant_d;
            key_q    <= key_d;
            kv_q     <= kv_d;
            issued_q <= issued_d;
            rr_q     <= rr_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.key          = key_q;
    assign bus.key_valid    = kv_q;
    assign bus.busy         = (state_q == RUN);
    assign bus.exhausted    = (state_q == DONE);
    assign bus.issued_count = issued_q;

endmodule

// File: tb/tb_lfsr_keyspace_dispenser.sv
// Directed self-checking bench for lfsr_keyspace_dispenser.
// Four instances: W4/1 core, W4/4 cores, W8/2 cores, W16/2 cores.
module tb_lfsr_keyspace_dispenser;

    logic clk;
    logic reset;

    int n_cmp = 0;
    int n_err = 0;

    lfsr_keyspace_dispenser_if #(.WIDTH(4),  .NUM_CH(1)) if_a ();
    lfsr_keyspace_dispenser_if #(.WIDTH(4),  .NUM_CH(4)) if_b ();
    lfsr_keyspace_dispenser_if #(.WIDTH(8),  .NUM_CH(2)) if_c ();
    lfsr_keyspace_dispenser_if #(.WIDTH(16), .NUM_CH(2)) if_d ();

    lfsr_keyspace_dispenser #(.WIDTH(4),  .NUM_CH(1)) u_a (.clk(clk), .reset(reset), .bus(if_a));
    lfsr_keyspace_dispenser #(.WIDTH(4),  .NUM_CH(4)) u_b (.clk(clk), .reset(reset), .bus(if_b));
    lfsr_keyspace_dispenser #(.WIDTH(8),  .NUM_CH(2)) u_c (.clk(clk), .reset(reset), .bus(if_c));
    lfsr_keyspace_dispenser #(.WIDTH(16), .NUM_CH(2)) u_d (.clk(clk), .reset(reset), .bus(if_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived W=4 sequence from seed 1 with taps 4'h9
    logic [3:0] seq4 [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                              4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

    bit seen8  [256];
    bit seen16 [65536];
    int n8;
    int n16;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        if_a.start = 1'b0; if_a.seed = '0; if_a.stop = 1'b0; if_a.req = '0;
        if_b.start = 1'b0; if_b.seed = '0; if_b.stop = 1'b0; if_b.req = '0;
        if_c.start = 1'b0; if_c.seed = '0; if_c.stop = 1'b0; if_c.req = '0;
        if_d.start = 1'b0; if_d.seed = '0; if_d.stop = 1'b0; if_d.req = '0;
        tick();
        tick();

        // Reset state
        check("rst_grant",     32'(if_b.grant),        32'd0);
        check("rst_key",       32'(if_b.key),          32'd0);
        check("rst_key_valid", 32'(if_b.key_valid),    32'd0);
        check("rst_busy",      32'(if_b.busy),         32'd0);
        check("rst_exhausted", 32'(if_b.exhausted),    32'd0);
        check("rst_issued",    32'(if_b.issued_count), 32'd0);
        reset = 1'b0;
        tick();

        // T1: single core, req held -> one grant every other cycle, full period
        if_a.seed = 4'h1; if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0; if_a.req = 1'b1;
        check("t1_busy",   32'(if_a.busy),         32'd1);
        check("t1_issued0", 32'(if_a.issued_count), 32'd0);
        for (int k = 0; k < 15; k++) begin
            tick();
            check($sformatf("t1_grant%0d", k),  32'(if_a.grant),        32'd1);
            check($sformatf("t1_key%0d", k),    32'(if_a.key),          32'(seq4[k]));
            check($sformatf("t1_count%0d", k),  32'(if_a.issued_count), 32'(k + 1));
            check($sformatf("t1_exh%0d", k),    32'(if_a.exhausted),    32'(k == 14));
            tick();
            check($sformatf("t1_mask%0d", k),   32'(if_a.grant),        32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t1_no16th", 32'(if_a.key_valid), 32'd0);
            check("t1_done",   32'(if_a.exhausted), 32'd1);
        end

        // T3: seed 0 becomes 1
        if_a.seed = 4'h0; if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        check("t3_restart_exh", 32'(if_a.exhausted),    32'd0);
        check("t3_restart_cnt", 32'(if_a.issued_count), 32'd0);
        tick();
        check("t3_seed0_key", 32'(if_a.key),   32'd1);
        check("t3_seed0_gnt", 32'(if_a.grant), 32'd1);
        if_a.stop = 1'b1;
        tick();
        check("t3_halt_busy", 32'(if_a.busy), 32'd0);
        if_a.stop = 1'b0;

        // T3: seed A, full period; last key is the one preceding A (D)
        if_a.seed = 4'hA; if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            check($sformatf("t3_key%0d", k), 32'(if_a.key),       32'(seq4[(6 + k) % 15]));
            check($sformatf("t3_exh%0d", k), 32'(if_a.exhausted), 32'(k == 14));
            tick();
        end
        check("t3_last_cnt", 32'(if_a.issued_count), 32'd15);
        check("t3_last_key", 32'(if_a.key),          32'hD);

        // T2: four cores held -> rotating grants every cycle
        if_b.seed = 4'h1; if_b.start = 1'b1;
        tick();
        if_b.start = 1'b0; if_b.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t2_grant%0d", k), 32'(if_b.grant),     32'(1) << (k % 4));
            check($sformatf("t2_key%0d", k),   32'(if_b.key),       32'(seq4[k]));
            check($sformatf("t2_kv%0d", k),    32'(if_b.key_valid), 32'd1);
        end

        // T4: stop -> no further grants, busy drops
        if_b.stop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_stop_grant", 32'(if_b.grant),        32'd0);
            check("t4_stop_busy",  32'(if_b.busy),         32'd0);
            check("t4_stop_cnt",   32'(if_b.issued_count), 32'd5);
        end
        if_b.stop = 1'b0; if_b.seed = 4'h7; if_b.start = 1'b1;
        tick();
        if_b.start = 1'b0;
        check("t4_restart_cnt",  32'(if_b.issued_count), 32'd0);
        check("t4_restart_busy", 32'(if_b.busy),         32'd1);
        check("t4_restart_gnt",  32'(if_b.grant),        32'd0);
        tick();
        // Last winner was core 0, so core 1 goes next
        check("t4_first_gnt", 32'(if_b.grant),        32'b0010);
        check("t4_first_key", 32'(if_b.key),          32'h7);
        check("t4_first_cnt", 32'(if_b.issued_count), 32'd1);
        if_b.req = 4'b0001;
        tick();
        check("t4_c0_gnt_a", 32'(if_b.grant), 32'b0001);
        check("t4_c0_key_a", 32'(if_b.key),   32'hF);
        tick();
        check("t4_c0_mask",  32'(if_b.grant), 32'd0);
        tick();
        check("t4_c0_gnt_b", 32'(if_b.grant),        32'b0001);
        check("t4_c0_key_b", 32'(if_b.key),          32'hE);
        check("t4_c0_cnt",   32'(if_b.issued_count), 32'd3);

        // T6: W8 and W16 full periods, uniqueness scoreboards
        seen8[0]  = 1'b1;  // pre-marked so a zero key shows up as a repeat
        seen16[0] = 1'b1;
        n8 = 0; n16 = 0;
        if_c.seed = 8'h1;  if_c.start = 1'b1;
        if_d.seed = 16'h1; if_d.start = 1'b1;
        tick();
        if_c.start = 1'b0; if_c.req = 2'b11;
        if_d.start = 1'b0; if_d.req = 2'b11;
        for (int cyc = 0; cyc < 65545; cyc++) begin
            tick();
            if (if_c.key_valid) begin
                n8++;
                check("t6_w8_unique", 32'(seen8[if_c.key]), 32'd0);
                seen8[if_c.key] = 1'b1;
                check("t6_w8_exh", 32'(if_c.exhausted), 32'(n8 == 255));
            end
            if (if_d.key_valid) begin
                n16++;
                check("t6_w16_unique", 32'(seen16[if_d.key]), 32'd0);
                seen16[if_d.key] = 1'b1;
                check("t6_w16_exh", 32'(if_d.exhausted), 32'(n16 == 65535));
            end
        end
        check("t6_w8_total",   32'(n8),                 32'd255);
        check("t6_w16_total",  32'(n16),                32'd65535);
        check("t6_w8_cnt",     32'(if_c.issued_count),  32'hFF);
        check("t6_w16_cnt",    32'(if_d.issued_count),  32'hFFFF);
        check("t6_w8_done",    32'(if_c.exhausted),     32'd1);
        check("t6_w16_done",   32'(if_d.exhausted),     32'd1);

        // T5: reset mid-run with requests high
        if_b.req = 4'b1111;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_grant",  32'(if_b.grant),        32'd0);
        check("t5_kv",     32'(if_b.key_valid),    32'd0);
        check("t5_busy",   32'(if_b.busy),         32'd0);
        check("t5_issued", 32'(if_b.issued_count), 32'd0);
        check("t5_key",    32'(if_b.key),          32'd0);
        check("t5_a_exh",  32'(if_a.exhausted),    32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_idle_grant", 32'(if_b.grant), 32'd0);
        end
        if_b.seed = 4'h1; if_b.start = 1'b1;
        tick();
        if_b.start = 1'b0;
        tick();
        // Pointer reset to NUM_CH-1, so core 0 wins first
        check("t5_after_gnt", 32'(if_b.grant), 32'b0001);
        check("t5_after_key", 32'(if_b.key),   32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
